// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM save controller.
// Holds the controller states, transfer modes and the 4-word save-image header.
package bk_pkg;

    localparam int BK_SECTORS_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_NEXT,
        S_FMT
    } bk_state_e;

    typedef enum logic [1:0] {
        M_LOAD,
        M_SAVE_ALL,
        M_SAVE_DIRTY
    } bk_mode_e;

    localparam logic [15:0] BK_HDR0 = 16'h5548;
    localparam logic [15:0] BK_HDR1 = 16'h4D42;
    localparam logic [15:0] BK_HDR2 = 16'h8800;
    localparam logic [15:0] BK_HDR3 = 16'h8010;

    function automatic logic [15:0] bk_hdr_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return BK_HDR0;
            2'd1:    return BK_HDR1;
            2'd2:    return BK_HDR2;
            default: return BK_HDR3;
        endcase
    endfunction

endpackage

// File: rtl/bk_dirty_map.sv
// Per-sector dirty bitmap with lowest-dirty-sector search; one-cycle update, no backpressure.
// Set requests win over a same-cycle clear so a write racing its own save is never lost.
module bk_dirty_map
    import bk_pkg::*;
#(
    parameter int SECTORS = BK_SECTORS_DEFAULT,
    parameter int SW      = $clog2(SECTORS)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [SECTORS-1:0] set_mask_i,
    input  logic               clr_vld_i,
    input  logic [SW-1:0]      clr_idx_i,
    input  logic               clr_all_i,
    output logic [SECTORS-1:0] dirty_o,
    output logic               any_o,
    output logic [SW-1:0]      first_o
);

    logic [SECTORS-1:0] dirty_q, dirty_d;
    logic [SECTORS-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        if (clr_vld_i) clr_mask[clr_idx_i] = 1'b1;
        if (clr_all_i) dirty_d = '0;
        else           dirty_d = (dirty_q & ~clr_mask) | set_mask_i;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) dirty_q <= '0;
        else       dirty_q <= dirty_d;
    end

    always_comb begin
        first_o = '0;
        for (int i = SECTORS - 1; i >= 0; i--) begin
            if (dirty_q[i]) first_o = SW'(i);
        end
    end

    assign dirty_o = dirty_q;
    assign any_o   = |dirty_q;

endmodule

// File: rtl/bk_save_ctrl.sv
// Sequences backup-RAM sector loads/saves with the HPS and writes the save-image header.
// One sector per sd_rd/sd_wr handshake; trigger edges outside IDLE are dropped.
module bk_save_ctrl
    import bk_pkg::*;
#(
    parameter int SECTORS = BK_SECTORS_DEFAULT,
    parameter int SW      = $clog2(SECTORS)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          downloading,
    input  logic          img_mounted,
    input  logic          img_readonly,
    input  logic [63:0]   img_size,
    input  logic          osd_status,
    input  logic          load_req,
    input  logic          save_req,
    input  logic          autosave_en,
    input  logic          format_req,
    input  logic          bram_wr,
    input  logic [SW-1:0] bram_sector,
    input  logic          sd_ack,
    output logic [31:0]   sd_lba,
    output logic          sd_rd,
    output logic          sd_wr,
    output logic          bk_ena,
    output logic          bk_pending,
    output logic          bk_state,
    output logic          bk_loading,
    output logic          fmt_we,
    output logic [1:0]    fmt_addr,
    output logic [15:0]   fmt_data
);

    bk_state_e     state_q, state_d;
    bk_mode_e      mode_q, mode_d;
    logic [SW-1:0] sector_q, sector_d;
    logic          done_q, done_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic          loading_q, loading_d;
    logic          pending_q, pending_d;
    logic          ena_q, ena_d;
    logic          dl_q, ld_q, sv_q, osd_q, fmt_q, ack_q;

    logic               pend_clr, fmt_mark, clr_vld, clr_all, core_wr;
    logic [SECTORS-1:0] set_mask, dirty;
    logic               any_dirty;
    logic [SW-1:0]      first_dirty;

    wire dl_rise  = downloading & ~dl_q;
    wire dl_fall  = ~downloading & dl_q;
    wire ld_rise  = load_req & ~ld_q;
    wire sv_rise  = save_req & ~sv_q;
    wire osd_rise = osd_status & ~osd_q;
    wire fmt_rise = format_req & ~fmt_q;
    wire ack_rise = sd_ack & ~ack_q;
    wire ack_fall = ~sd_ack & ack_q;

    wire start_load = ena_q & ((dl_fall & (|img_size)) | ld_rise);
    wire start_save = ena_q & sv_rise;
    wire start_auto = ena_q & osd_rise & pending_q & autosave_en;

    assign core_wr = bram_wr & ena_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sector_d  = sector_q;
        done_d    = done_q;
        fcnt_d    = fcnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        loading_d = loading_q;
        pend_clr  = 1'b0;
        fmt_mark  = 1'b0;
        clr_vld   = 1'b0;
        clr_all   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    mode_d    = M_LOAD;
                    sector_d  = '0;
                    loading_d = 1'b1;
                    pend_clr  = 1'b1;
                    state_d   = S_REQ;
                end else if (start_save) begin
                    mode_d   = M_SAVE_ALL;
                    sector_d = '0;
                    pend_clr = 1'b1;
                    state_d  = S_REQ;
                end else if (start_auto) begin
                    // Nothing dirty means nothing to write: stay put.
                    if (any_dirty) begin
                        mode_d   = M_SAVE_DIRTY;
                        sector_d = first_dirty;
                        pend_clr = 1'b1;
                        state_d  = S_REQ;
                    end
                end else if (fmt_rise) begin
                    fcnt_d  = '0;
                    state_d = S_FMT;
                end
            end
            S_REQ: begin
                rd_d    = (mode_q == M_LOAD);
                wr_d    = (mode_q != M_LOAD);
                state_d = S_XFER;
            end
            S_XFER: begin
                if (ack_rise) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                end
                if (ack_fall) begin
                    done_d  = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // done_q=0 marks a sector reached by skipping, not yet transferred.
                if (done_q && mode_q != M_LOAD) clr_vld = 1'b1;
                if (!done_q && dirty[sector_q]) begin
                    state_d = S_REQ;
                end else if (sector_q == SW'(SECTORS - 1)) begin
                    state_d = S_IDLE;
                    if (mode_q == M_LOAD) begin
                        loading_d = 1'b0;
                        clr_all   = 1'b1;
                    end
                end else begin
                    sector_d = sector_q + SW'(1);
                    if (mode_q == M_SAVE_DIRTY) done_d = 1'b0;
                    else                        state_d = S_REQ;
                end
            end
            S_FMT: begin
                fcnt_d = fcnt_q + 2'd1;
                if (fcnt_q == 2'd3) begin
                    fmt_mark = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (pend_clr) pending_d = 1'b0;
        if ((core_wr && !osd_status) || fmt_mark) pending_d = 1'b1;

        ena_d = ena_q;
        if (dl_rise)                                          ena_d = 1'b0;
        else if (downloading && img_mounted && !img_readonly) ena_d = 1'b1;

        set_mask = '0;
        if (core_wr)  set_mask[bram_sector] = 1'b1;
        if (fmt_mark) set_mask[0] = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= M_LOAD;
            sector_q  <= '0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            loading_q <= 1'b0;
            pending_q <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sector_q  <= sector_d;
            done_q    <= done_d;
            fcnt_q    <= fcnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            loading_q <= loading_d;
            pending_q <= pending_d;
            ena_q     <= ena_d;
        end
    end

    // Edge history tracks the inputs even through reset, so release never fakes an edge.
    always_ff @(posedge clk_sys) begin
        dl_q  <= downloading;
        ld_q  <= load_req;
        sv_q  <= save_req;
        osd_q <= osd_status;
        fmt_q <= format_req;
        ack_q <= sd_ack;
    end

    bk_dirty_map #(
        .SECTORS(SECTORS),
        .SW     (SW)
    ) u_map (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .set_mask_i(set_mask),
        .clr_vld_i (clr_vld),
        .clr_idx_i (sector_q),
        .clr_all_i (clr_all),
        .dirty_o   (dirty),
        .any_o     (any_dirty),
        .first_o   (first_dirty)
    );

    assign sd_lba     = 32'(sector_q);
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_pending = pending_q;
    assign bk_loading = loading_q;
    assign bk_state   = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_NEXT);
    assign fmt_we     = (state_q == S_FMT);
    assign fmt_addr   = fmt_we ? fcnt_q : 2'd0;
    assign fmt_data   = fmt_we ? bk_hdr_word(fcnt_q) : 16'd0;

endmodule

// File: tb/tb_bk_save_ctrl.sv
// Directed + randomized bench for bk_save_ctrl with an HPS responder and a sector-list model.
// The model predicts each operation's transfer list and the dirty/pending state afterwards.
module tb_bk_save_ctrl;

    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        osd_status = 1'b0, load_req = 1'b0, save_req = 1'b0;
    logic        autosave_en = 1'b1, format_req = 1'b0, bram_wr = 1'b0;
    logic [3:0]  bram_sector = 4'd0;
    logic        ack_auto = 1'b0, ack_man = 1'b0;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_pending, bk_state, bk_loading, fmt_we;
    logic [1:0]  fmt_addr;
    logic [15:0] fmt_data;

    assign sd_ack = ack_auto | ack_man;

    always #5 clk = ~clk;

    bk_save_ctrl #(.SECTORS(NS)) dut (
        .clk_sys(clk), .reset(reset), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .osd_status(osd_status), .load_req(load_req), .save_req(save_req),
        .autosave_en(autosave_en), .format_req(format_req), .bram_wr(bram_wr),
        .bram_sector(bram_sector), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_pending(bk_pending), .bk_state(bk_state),
        .bk_loading(bk_loading), .fmt_we(fmt_we), .fmt_addr(fmt_addr), .fmt_data(fmt_data)
    );

    int checks = 0;
    int errors = 0;
    int stall_lba = -1;

    // Transfer entry: {is_write, loading, lba[7:0]}
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];

    logic [NS-1:0] m_dirty = '0;
    logic          m_pend = 1'b0;
    logic          m_ena = 1'b0;
    logic [15:0]   hdr_tab[4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // HPS side: acknowledge each request after one cycle, hold ack for two.
    initial begin
        forever begin
            @(negedge clk);
            if ((sd_rd || sd_wr) && !(stall_lba >= 0 && sd_lba == 32'(stall_lba))) begin
                obs_q.push_back({sd_wr, bk_loading, sd_lba[7:0]});
                @(negedge clk);
                ack_auto = 1'b1;
                repeat (2) @(negedge clk);
                ack_auto = 1'b0;
            end
        end
    end

    task automatic exp_load();
        for (int i = 0; i < NS; i++) exp_q.push_back({1'b0, 1'b1, 8'(i)});
        m_dirty = '0;
        m_pend  = 1'b0;
    endtask

    task automatic exp_full_save();
        for (int i = 0; i < NS; i++) exp_q.push_back({1'b1, 1'b0, 8'(i)});
        m_dirty = '0;
        m_pend  = 1'b0;
    endtask

    task automatic exp_dirty_save();
        for (int i = 0; i < NS; i++)
            if (m_dirty[i]) exp_q.push_back({1'b1, 1'b0, 8'(i)});
        m_dirty = '0;
        m_pend  = 1'b0;
    endtask

    task automatic check_xfers(input string tag);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_until_idle();
        int n = 0;
        while (bk_state && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 3000), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic core_write(input int sec);
        @(negedge clk);
        bram_wr = 1'b1;
        bram_sector = 4'(sec);
        if (m_ena) begin
            m_dirty[sec] = 1'b1;
            if (!osd_status) m_pend = 1'b1;
        end
        @(negedge clk);
        bram_wr = 1'b0;
    endtask

    task automatic do_op(input int op);
        @(negedge clk);
        case (op)
            0: begin load_req = 1'b1; exp_load(); end
            1: begin save_req = 1'b1; exp_full_save(); end
            default: begin
                osd_status = 1'b1;
                if (m_ena && m_pend && autosave_en && m_dirty != '0) exp_dirty_save();
            end
        endcase
        @(negedge clk);
        load_req = 1'b0;
        save_req = 1'b0;
        run_until_idle();
        osd_status = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({sd_rd, sd_wr, bk_state, bk_loading, bk_pending, bk_ena,
                    fmt_we, fmt_addr, fmt_data, sd_lba});
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);

        // Mount: read-only image must not enable, read-write must.
        downloading = 1'b1;
        img_size = 64'd8192;
        repeat (2) @(negedge clk);
        img_readonly = 1'b1; img_mounted = 1'b1;
        @(negedge clk); img_mounted = 1'b0;
        @(negedge clk);
        chk("ena_ro", 64'(bk_ena), 64'd0);
        img_readonly = 1'b0; img_mounted = 1'b1;
        @(negedge clk); img_mounted = 1'b0;
        @(negedge clk);
        m_ena = 1'b1;
        chk("ena_rw", 64'(bk_ena), 64'(m_ena));

        // End of download triggers a full load.
        downloading = 1'b0;
        exp_load();
        @(negedge clk);
        run_until_idle();
        check_xfers("dl_load");
        chk("load_done_loading", 64'(bk_loading), 64'd0);
        chk("load_map", 64'(dut.u_map.dirty_o), 64'(m_dirty));

        // Autosave writes only the dirty sectors, ascending.
        core_write(9);
        core_write(3);
        chk("pend_set", 64'(bk_pending), 64'(m_pend));
        do_op(2);
        check_xfers("auto39");
        chk("auto39_pend", 64'(bk_pending), 64'(m_pend));
        chk("auto39_map", 64'(dut.u_map.dirty_o), 64'(m_dirty));

        for (int it = 0; it < 6; it++) begin
            int nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) core_write($urandom_range(0, NS - 1));
            chk($sformatf("rnd%0d_pend_pre", it), 64'(bk_pending), 64'(m_pend));
            do_op($urandom_range(0, 2));
            check_xfers($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_pend", it), 64'(bk_pending), 64'(m_pend));
            chk($sformatf("rnd%0d_map", it), 64'(dut.u_map.dirty_o), 64'(m_dirty));
        end

        // Load and save in the same cycle -> load; save during load -> dropped.
        core_write(2);
        @(negedge clk);
        load_req = 1'b1; save_req = 1'b1;
        exp_load();
        @(negedge clk);
        load_req = 1'b0; save_req = 1'b0;
        repeat (20) @(negedge clk);
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        run_until_idle();
        repeat (10) @(negedge clk);
        check_xfers("ld_sv");
        chk("ld_sv_state", 64'(bk_state), 64'd0);

        // Format: four header words then sector 0 dirty.
        format_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            format_req = 1'b0;
            chk($sformatf("fmt_%0d", k), 64'({fmt_we, fmt_addr, fmt_data}),
                64'({1'b1, 2'(k), hdr_tab[k]}));
        end
        @(negedge clk);
        m_dirty[0] = 1'b1;
        m_pend = 1'b1;
        chk("fmt_end_we", 64'(fmt_we), 64'd0);
        chk("fmt_pend", 64'(bk_pending), 64'(m_pend));
        do_op(2);
        check_xfers("fmt_auto");

        // Core write to sector 5 during its own NEXT cycle must survive the save.
        @(negedge clk);
        save_req = 1'b1;
        exp_full_save();
        @(negedge clk);
        save_req = 1'b0;
        n = 0;
        while (!(sd_wr && sd_lba == 32'd5) && n < 2000) begin @(negedge clk); n++; end
        while (!sd_ack && n < 2000) begin @(negedge clk); #1; n++; end
        while (sd_ack && n < 2000) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bram_wr = 1'b1; bram_sector = 4'd5;
        m_dirty[5] = 1'b1; m_pend = 1'b1;
        @(negedge clk);
        bram_wr = 1'b0;
        chk("race_timeout", 64'(n < 2000), 64'd1);
        run_until_idle();
        check_xfers("race_save");
        chk("race_map", 64'(dut.u_map.dirty_o), 64'(m_dirty));
        chk("race_pend", 64'(bk_pending), 64'(m_pend));
        do_op(2);
        check_xfers("race_auto");

        // Reset while sector 7 is mid-transfer; the late ack fall must do nothing.
        stall_lba = 7;
        @(negedge clk);
        save_req = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b1, 1'b0, 8'(i)});
        @(negedge clk);
        save_req = 1'b0;
        n = 0;
        while (!(sd_wr && sd_lba == 32'd7) && n < 2000) begin @(negedge clk); n++; end
        chk("rst_wait", 64'(n < 2000), 64'd1);
        ack_man = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 64'd0);
        reset = 1'b0;
        ack_man = 1'b0;
        m_ena = 1'b0; m_dirty = '0; m_pend = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_late_ack", all_outs(), 64'd0);
        check_xfers("rst_abort");
        chk("rst_map", 64'(dut.u_map.dirty_o), 64'(m_dirty));
        stall_lba = -1;

        // Without a usable image a save request is ignored.
        do_op(1);
        obs_q.delete();
        exp_q.delete();
        repeat (6) @(negedge clk);
        chk("no_ena_state", 64'(bk_state), 64'd0);
        chk("no_ena_wr", 64'({sd_rd, sd_wr}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
